multicycle_control: RTL and testbench

Multicycle MIPS control FSM that sequences the shared datapath (single memory, single ALU, IR, PC, register file) over fetch/decode/execute/memory/write-back states. It decodes the IR opcode and drives all mux selects, write enables and ALUOp each cycle. Memory accesses use a ready handshake with a timeout watchdog. The ALU-control decoder downstream consumes alu_op unchanged.

---
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, with a memory-ready handshake and a timeout watchdog.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_IDLE     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = WD_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            is_wait, at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Memory handshake: the request (mem_read/mem_write) is held for as long as
  // the FSM sits in a wait state; a transfer completes in the cycle where the
  // request and mem_ready are both high, and only then do the completion
  // strobes fire. mem_ready in the watchdog limit cycle still completes.
  assign is_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign at_limit = WD_EN && (wait_cnt_q == TO_LIMIT) && !mem_ready;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_fault     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (at_limit) begin
          mem_fault = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op_code)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (at_limit) begin
          mem_fault = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (at_limit) begin
          mem_fault = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The wait counter restarts on every state change so each request gets a full budget.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (is_wait && !mem_ready)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT_CYCLES=4): expected state and
// control vector pushed per step, popped and checked at the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op, mem_fault;
  logic [3:0] state;

  localparam int W = 23;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  multicycle_control #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .state(state)
  );

  always #5 clk = ~clk;

  // Reference control vector straight from the state table.
  function automatic logic [W-1:0] ref_vec(input logic [3:0] st, input logic [5:0] op,
                                           input logic rdy, input logic lim);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn, ill, flt;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, dn, ill, flt} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; flt = lim & ~rdy; end
      4'd1:  begin sb = 2'b11;
                   ill = !(op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8}); end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; flt = lim & ~rdy; end
      4'd4:  begin m2r = 1; rw = 1; dn = 1; end
      4'd5:  begin mw = 1; iod = 1; dn = rdy; flt = lim & ~rdy; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      4'd9:  begin pw = 1; ps = 2'b10; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {st, pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, dn, ill, flt};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
            instr_done, illegal_op, mem_fault};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] e, o;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs_vec());
      return;
    end
    e = exp_q.pop_front();
    o = obs_vec();
    n_vec++;
    if (instr_done) done_cnt++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, o, e, o[W-1 -: 4], e[W-1 -: 4]);
    end
  endtask

  // One clock: drive inputs, record expectation, compare at negedge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic [3:0] es, input logic lim);
    op_code = op;
    mem_ready = rdy;
    exp_q.push_back(ref_vec(es, op, rdy, lim));
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic scalar_check(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    // Reset held: IDLE with every output low.
    mem_ready = 1'b1;
    exp_q.push_back(ref_vec(4'd15, 6'd0, 1'b1, 1'b0));
    @(negedge clk);
    check("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type: 15,0,1,6,7,0
    cyc("r_idle", 6'd0, 1, 4'd15, 0);
    cyc("r_fetch", 6'd0, 1, 4'd0, 0);
    cyc("r_decode", 6'd0, 1, 4'd1, 0);
    cyc("r_exec", 6'd0, 1, 4'd6, 0);
    cyc("r_wb", 6'd0, 1, 4'd7, 0);

    // lw with three stalled cycles in MEM_RD; the fourth reaches the limit with ready.
    cyc("lw_fetch", 6'd35, 1, 4'd0, 0);
    cyc("lw_decode", 6'd35, 1, 4'd1, 0);
    cyc("lw_addr", 6'd35, 1, 4'd2, 0);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 6'd35, 0, 4'd3, 0);
    cyc("lw_rd_ready", 6'd35, 1, 4'd3, 1);
    cyc("lw_wb", 6'd35, 1, 4'd4, 0);

    // sw then beq back to back; instr_done must fire exactly twice.
    done_cnt = 0;
    cyc("sw_fetch", 6'd43, 1, 4'd0, 0);
    cyc("sw_decode", 6'd43, 1, 4'd1, 0);
    cyc("sw_addr", 6'd43, 1, 4'd2, 0);
    cyc("sw_wr", 6'd43, 1, 4'd5, 0);
    cyc("beq_fetch", 6'd4, 1, 4'd0, 0);
    cyc("beq_decode", 6'd4, 1, 4'd1, 0);
    cyc("beq_branch", 6'd4, 1, 4'd8, 0);
    scalar_check("sw_beq_done_count", done_cnt, 2);

    // Illegal opcode then jump and addi.
    cyc("ill_fetch", 6'd63, 1, 4'd0, 0);
    cyc("ill_decode", 6'd63, 1, 4'd1, 0);
    cyc("j_fetch", 6'd2, 1, 4'd0, 0);
    cyc("j_decode", 6'd2, 1, 4'd1, 0);
    cyc("j_jump", 6'd2, 1, 4'd9, 0);
    cyc("addi_fetch", 6'd8, 1, 4'd0, 0);
    cyc("addi_decode", 6'd8, 1, 4'd1, 0);
    cyc("addi_ex", 6'd8, 1, 4'd10, 0);
    cyc("addi_wb", 6'd8, 1, 4'd11, 0);

    // Fetch timeout: fault in the fourth wait cycle, then back through IDLE.
    for (int i = 0; i < 3; i++) cyc("to_wait", 6'd0, 0, 4'd0, 0);
    cyc("to_fault", 6'd0, 0, 4'd0, 1);
    cyc("to_idle", 6'd0, 0, 4'd15, 0);
    // Ready arriving in the limit cycle wins.
    for (int i = 0; i < 3; i++) cyc("rdy_wait", 6'd43, 0, 4'd0, 0);
    cyc("rdy_limit", 6'd43, 1, 4'd0, 1);
    cyc("rdy_decode", 6'd43, 1, 4'd1, 0);
    cyc("rst_addr", 6'd43, 1, 4'd2, 0);

    // Reset asserted mid MEM_WR with ready high: outputs clear without a clock edge.
    op_code = 6'd43;
    mem_ready = 1'b1;
    exp_q.push_back(ref_vec(4'd5, 6'd43, 1'b1, 1'b0));
    @(negedge clk);
    check("rst_pre_wr");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(ref_vec(4'd15, 6'd43, 1'b1, 1'b0));
    check("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(ref_vec(4'd15, 6'd43, 1'b1, 1'b0));
    check("rst_hold");
    rst_n = 1'b1;
    cyc("rst_release", 6'd0, 1, 4'd15, 0);
    cyc("rst_refetch", 6'd0, 1, 4'd0, 0);
    scalar_check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, observed state %0d", state);
    $fatal(1, "bench timeout");
  end

endmodule
